// File: rtl/ad_bus_pkg.sv
// rtl/ad_bus_pkg.sv - shared types and constants for the multiplexed A/D bus target
package ad_bus_pkg;

    localparam int DWIDTH      = 32;
    localparam int TURN_CYCLES = 1;
    // Word index sits just above the two byte-lane bits of the address
    localparam int IDX_LSB     = 2;
    localparam int ADDR_MSB    = DWIDTH - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_TURNBACK,
        ST_WAITEND
    } state_t;

endpackage

// File: rtl/ad_bus_regfile.sv
// rtl/ad_bus_regfile.sv - local word store, one synchronous write port, one combinational read port
module ad_bus_regfile
    import ad_bus_pkg::*;
#(
    parameter int AWIDTH = 4
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ad_bus_target.sv
// rtl/ad_bus_target.sv - responder on the multiplexed A/D pad bus with turnaround and burst stop
module ad_bus_target
    import ad_bus_pkg::*;
#(
    parameter int                                  AWIDTH    = 4,
    parameter logic [DWIDTH-AWIDTH-IDX_LSB-1:0]    BASE      = 26'h0000040,
    parameter int                                  MAX_BURST = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Frame,
    input  logic              Write,
    input  logic              Valid,
    input  logic [DWIDTH-1:0] ADIn,
    output logic [DWIDTH-1:0] ADOut,
    output logic              ADOE,
    output logic              Ready,
    output logic              Stop,
    output logic              Busy
);

    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam int            TW         = $clog2(TURN_CYCLES + 1);
    localparam logic [BW-1:0] BEAT_LIMIT = BW'(MAX_BURST);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);

    state_t            state, state_n;
    logic [AWIDTH-1:0] idx, idx_n, raddr;
    logic [BW-1:0]     beats, beats_n;
    logic [TW-1:0]     turn_cnt, turn_cnt_n;
    logic              accept, we, load_out;
    logic              adoe_n, ready_n, stop_n, busy_n;
    logic [DWIDTH-1:0] rdata;

    ad_bus_regfile #(.AWIDTH(AWIDTH)) u_regfile (
        .Clk   (Clk),
        .we    (we),
        .waddr (idx),
        .wdata (ADIn),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        beats_n    = beats;
        turn_cnt_n = '0;
        we         = 1'b0;
        load_out   = 1'b0;
        raddr      = idx;
        // Once the burst limit is reached further beats are refused
        accept     = Valid && (beats != BEAT_LIMIT);

        unique case (state)
            ST_IDLE: begin
                if (Frame) begin
                    idx_n   = ADIn[AWIDTH+IDX_LSB-1:IDX_LSB];
                    beats_n = '0;
                    if (ADIn[ADDR_MSB:AWIDTH+IDX_LSB] != BASE) begin
                        state_n = ST_WAITEND;
                    end else if (Write) begin
                        state_n = ST_WDATA;
                    end else begin
                        state_n = ST_TURN;
                    end
                end
            end
            ST_WDATA: begin
                if (accept) begin
                    we      = 1'b1;
                    idx_n   = idx + AWIDTH'(1);
                    beats_n = beats + BW'(1);
                end
                if (!Frame) begin
                    state_n = ST_IDLE;
                end
            end
            ST_TURN: begin
                load_out = 1'b1;
                if (turn_cnt == TURN_LAST) begin
                    state_n = ST_RDATA;
                end else begin
                    turn_cnt_n = turn_cnt + TW'(1);
                end
            end
            ST_RDATA: begin
                if (accept) begin
                    idx_n    = idx + AWIDTH'(1);
                    beats_n  = beats + BW'(1);
                    raddr    = idx_n;
                    load_out = 1'b1;
                end
                if (!Frame) begin
                    state_n = ST_TURNBACK;
                end
            end
            ST_TURNBACK: begin
                if (turn_cnt == TURN_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    turn_cnt_n = turn_cnt + TW'(1);
                end
            end
            ST_WAITEND: begin
                if (!Frame) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Pad controls are derived from the upcoming state so they toggle with it
        busy_n  = (state_n != ST_IDLE);
        adoe_n  = (state_n == ST_RDATA);
        stop_n  = ((state_n == ST_WDATA) || (state_n == ST_RDATA)) && (beats_n == BEAT_LIMIT);
        ready_n = ((state_n == ST_WDATA) || (state_n == ST_RDATA)) && (beats_n != BEAT_LIMIT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            beats    <= '0;
            turn_cnt <= '0;
            ADOut    <= '0;
            ADOE     <= 1'b0;
            Ready    <= 1'b0;
            Stop     <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            beats    <= beats_n;
            turn_cnt <= turn_cnt_n;
            ADOE     <= adoe_n;
            Ready    <= ready_n;
            Stop     <= stop_n;
            Busy     <= busy_n;
            if (load_out) begin
                ADOut <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_ad_bus_target.sv
// tb/tb_ad_bus_target.sv - vector table, corner sequences and random transactions for ad_bus_target
module tb_ad_bus_target;

    localparam logic [25:0] TB_BASE = 26'h10;
    localparam int          DEPTH   = 16;
    localparam int          LIMIT   = 8;
    localparam int          NV      = 23;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Frame, Write, Valid;
    logic [31:0] ADIn, ADOut;
    logic        ADOE, Ready, Stop, Busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_model [DEPTH];

    typedef struct packed {
        logic        f;
        logic        w;
        logic        v;
        logic [31:0] ad;
        logic [3:0]  ctl;
        logic        chk;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs [NV];

    always #5 Clk = ~Clk;

    ad_bus_target #(.AWIDTH(4), .BASE(TB_BASE), .MAX_BURST(LIMIT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Frame (Frame),
        .Write (Write),
        .Valid (Valid),
        .ADIn  (ADIn),
        .ADOut (ADOut),
        .ADOE  (ADOE),
        .Ready (Ready),
        .Stop  (Stop),
        .Busy  (Busy)
    );

    function automatic vec_t mkv(logic f, logic w, logic v, logic [31:0] ad,
                                 logic [3:0] ctl, logic chk, logic [31:0] e_out);
        vec_t r;
        r = '{f: f, w: w, v: v, ad: ad, ctl: ctl, chk: chk, e_out: e_out};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ctl nibble is {ADOE, Ready, Stop, Busy}
    task automatic check_ctl(input string name, input logic oe, input logic rdy,
                             input logic stp, input logic bsy);
        check(name, {28'h0, ADOE, Ready, Stop, Busy}, {28'h0, oe, rdy, stp, bsy});
    endtask

    task automatic drive(input logic f, input logic w, input logic v, input logic [31:0] ad);
        Frame = f;
        Write = w;
        Valid = v;
        ADIn  = ad;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] hit_addr(input int i);
        return {TB_BASE, 4'(i), 2'($urandom)};
    endfunction

    task automatic do_write(input int start, input int n, input bit gaps);
        int done;
        int k;
        logic [31:0] d;
        done = 0;
        k    = 0;
        drive(1'b1, 1'b1, 1'b0, hit_addr(start));
        step();
        while (k < n) begin
            check_ctl("wr_beat", 1'b0, done < LIMIT, done >= LIMIT, 1'b1);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                drive(1'b1, 1'b1, 1'b0, $urandom);
            end else begin
                d = $urandom;
                drive(k != n - 1, 1'b1, 1'b1, d);
                if (done < LIMIT) begin
                    mem_model[(start + done) % DEPTH] = d;
                    done++;
                end
                k++;
            end
            step();
        end
        check_ctl("wr_end", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_read(input int start, input int n, input bit gaps);
        int done;
        int k;
        done = 0;
        k    = 0;
        drive(1'b1, 1'b0, 1'b0, hit_addr(start));
        step();
        check_ctl("rd_turn", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, $urandom);
        step();
        while (k < n) begin
            check_ctl("rd_beat", 1'b1, done < LIMIT, done >= LIMIT, 1'b1);
            if (done < LIMIT) begin
                check("rd_data", ADOut, mem_model[(start + done) % DEPTH]);
            end
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                drive(1'b1, 1'b0, 1'b0, $urandom);
            end else begin
                drive(k != n - 1, 1'b0, 1'b1, $urandom);
                if (done < LIMIT) begin
                    done++;
                end
                k++;
            end
            step();
        end
        check_ctl("rd_turnback", 1'b0, 1'b0, 1'b0, 1'b1);
        // Whatever the initiator presents during turnaround must not start a transaction
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              hit_addr($urandom_range(0, 15)));
        step();
        check_ctl("rd_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_miss(input int cycles);
        logic [25:0] up;
        do begin
            up = 26'($urandom);
        end while (up == TB_BASE);
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, {up, 6'($urandom)});
        step();
        repeat (cycles) begin
            check_ctl("miss", 1'b0, 1'b0, 1'b0, 1'b1);
            drive(1'b1, Write, 1'($urandom_range(0, 1)), $urandom);
            step();
        end
        check_ctl("miss_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, Write, 1'($urandom_range(0, 1)), $urandom);
        step();
        check_ctl("miss_end", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = mkv(1'b1, 1'b1, 1'b0, 32'h0000_0408, 4'b0101, 1'b0, 32'h0);
        vecs[1]  = mkv(1'b1, 1'b1, 1'b1, 32'h0000_00A1, 4'b0101, 1'b0, 32'h0);
        vecs[2]  = mkv(1'b1, 1'b1, 1'b1, 32'h0000_00B2, 4'b0101, 1'b0, 32'h0);
        vecs[3]  = mkv(1'b0, 1'b1, 1'b1, 32'h0000_00C3, 4'b0000, 1'b0, 32'h0);
        vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 32'h0000_0408, 4'b0001, 1'b0, 32'h0);
        vecs[5]  = mkv(1'b1, 1'b0, 1'b0, 32'h0,         4'b1101, 1'b1, 32'h0000_00A1);
        vecs[6]  = mkv(1'b1, 1'b0, 1'b1, 32'h0,         4'b1101, 1'b1, 32'h0000_00B2);
        vecs[7]  = mkv(1'b1, 1'b0, 1'b1, 32'h0,         4'b1101, 1'b1, 32'h0000_00C3);
        vecs[8]  = mkv(1'b0, 1'b0, 1'b1, 32'h0,         4'b0001, 1'b0, 32'h0);
        vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        vecs[10] = mkv(1'b1, 1'b1, 1'b0, 32'h0000_043C, 4'b0101, 1'b0, 32'h0);
        vecs[11] = mkv(1'b1, 1'b1, 1'b1, 32'hDEAD_0001, 4'b0101, 1'b0, 32'h0);
        vecs[12] = mkv(1'b0, 1'b1, 1'b1, 32'hDEAD_0002, 4'b0000, 1'b0, 32'h0);
        vecs[13] = mkv(1'b1, 1'b0, 1'b0, 32'h0000_043C, 4'b0001, 1'b0, 32'h0);
        vecs[14] = mkv(1'b1, 1'b0, 1'b0, 32'h0,         4'b1101, 1'b1, 32'hDEAD_0001);
        vecs[15] = mkv(1'b1, 1'b0, 1'b1, 32'h0,         4'b1101, 1'b1, 32'hDEAD_0002);
        vecs[16] = mkv(1'b0, 1'b0, 1'b1, 32'h0,         4'b0001, 1'b0, 32'h0);
        vecs[17] = mkv(1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        vecs[18] = mkv(1'b1, 1'b0, 1'b0, 32'h0000_0808, 4'b0001, 1'b0, 32'h0);
        vecs[19] = mkv(1'b1, 1'b0, 1'b1, 32'h0,         4'b0001, 1'b0, 32'h0);
        vecs[20] = mkv(1'b1, 1'b1, 1'b1, 32'h0,         4'b0001, 1'b0, 32'h0);
        vecs[21] = mkv(1'b1, 1'b0, 1'b0, 32'h0,         4'b0001, 1'b0, 32'h0);
        vecs[22] = mkv(1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);

        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_ctl("reset_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_adout", ADOut, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].f, vecs[i].w, vecs[i].v, vecs[i].ad);
            step();
            check($sformatf("vec%0d_ctl", i), {28'h0, ADOE, Ready, Stop, Busy}, {28'h0, vecs[i].ctl});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_data", i), ADOut, vecs[i].e_out);
            end
        end

        do_write(0, 8, 1'b0);
        do_write(8, 8, 1'b0);
        do_read(0, 10, 1'b0);
        do_write(4, 10, 1'b0);
        do_read(4, 9, 1'b0);
        do_write(14, 4, 1'b0);
        do_read(13, 6, 1'b0);

        // Reset in the middle of a read burst
        drive(1'b1, 1'b0, 1'b0, hit_addr(0));
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check("mid_beat1", ADOut, mem_model[0]);
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        step();
        check_ctl("mid_beat2_ctl", 1'b1, 1'b1, 1'b0, 1'b1);
        check("mid_beat2", ADOut, mem_model[1]);
        #2;
        Reset = 1'b1;
        #1;
        check_ctl("mid_reset_ctl", 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_adout", ADOut, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        Reset = 1'b0;
        step();
        check_ctl("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        do_write(5, 3, 1'b0);
        do_read(5, 3, 1'b0);
        do_read(0, 2, 1'b0);

        for (int t = 0; t < 80; t++) begin
            int kind;
            int st;
            int n;
            kind = int'($urandom_range(0, 2));
            st   = int'($urandom_range(0, 15));
            n    = int'($urandom_range(1, 11));
            case (kind)
                0:       do_write(st, n, 1'b1);
                1:       do_read(st, n, 1'b1);
                default: do_miss(int'($urandom_range(1, 4)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ad_bus_target.md
Name: ad_bus_target

Overview:
- Responder end of the shared 32-bit multiplexed address/data pad bus.
- Samples the address phase from the pad-input path and decodes a base-address hit.
- Services single or burst writes/reads against a local 16-word register store.
- Generates the output-enable and data for the tristate pad driver, with mandatory bus turnaround cycles so target and initiator never drive the pads simultaneously.

Parameters:
AWIDTH, 4, word-index width; store depth = 2**AWIDTH
BASE, 26'h0000040, match value for ADIn[31:AWIDTH+2]
MAX_BURST, 8, maximum beats per transaction before target stop

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high reset
Frame  input  1  initiator transaction frame; rising level starts address phase
Write  input  1  direction, sampled with address phase (1=write)
Valid  input  1  initiator beat strobe (write data present / read data accepted)
ADIn  input  32  registered pad-input data (address or write data)
ADOut  output  32  read data to pad driver
ADOE  output  1  pad output enable; 1 = target drives ADPad
Ready  output  1  target ready for data beats
Stop  output  1  target stop, burst limit reached
Busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (async, any time including mid-read): state=IDLE; ADOE=0, Ready=0, Stop=0, Busy=0, ADOut=0; index and beat counters cleared; store contents not reset.
- All outputs registered; ADOE falls in the same cycle Reset asserts.
- States: IDLE, WDATA, TURN, RDATA, TURNBACK, WAITEND.
- IDLE, Frame=1:
  - Latch idx=ADIn[AWIDTH+1:2] and dir=Write; beats=0.
  - hit = (ADIn[31:AWIDTH+2]==BASE).
  - hit & Write -> WDATA; hit & !Write -> TURN; miss -> WAITEND.
- WDATA: Ready=1, ADOE=0.
  - Each cycle with Valid=1: store[idx]<=ADIn; idx<=idx+1 (wraps modulo depth); beats++.
  - Frame=0 with Valid=1 is the final beat; it is written, then -> IDLE.
  - Frame=0 with Valid=0 -> IDLE, no write.
- TURN: exactly one cycle; ADOE=0, Ready=0; ADOut<=store[idx]; -> RDATA.
- RDATA: ADOE=1, Ready=1, ADOut holds store[idx].
  - Valid=1 accepts the beat: idx++ (wrap), ADOut<=store[idx+1], beats++.
  - Frame=0 with Valid=1 -> TURNBACK.
- TURNBACK: one cycle; ADOE=0, Ready=0; Frame ignored; -> IDLE.
- Read latency: address cycle T0, TURN T1, first data with ADOE=Ready=1 at T2.
- Burst limit, beats==MAX_BURST in WDATA/RDATA:
  - Ready<=0, Stop<=1; further Valid ignored (no write, no idx change).
  - Stop holds until Frame=0; then write -> IDLE, read -> TURNBACK (ADOE=0 there); Stop<=0.
- WAITEND: no outputs asserted; -> IDLE when Frame=0. A miss never asserts ADOE.
- Frame=1 on the IDLE cycle directly after TURNBACK starts a new transaction normally.
- Frame=1 during TURNBACK is never decoded.
- Busy = (state != IDLE), registered.

Decomposition:
- Package ad_bus_pkg: state enumeration; DWIDTH=32; TURN_CYCLES=1; address field slice constants.
- One sub-module: ad_bus_regfile, 2**AWIDTH x 32, one synchronous write port, one read port (registered by the parent into ADOut).
- FSM, counters and decode live in ad_bus_target.

Test Plan:
- Write burst: Frame=1, Write=1, ADIn=0x00000408 (idx 2), then 3 Valid beats 0xA1, 0xB2, 0xC3 (Frame=0 on last) -> store[2..4]=A1,B2,C3; ADOE stays 0 throughout; Busy returns 0 the next cycle.
- Read back: address 0x00000408, Write=0 -> T1 ADOE=0, T2 ADOE=1, ADOut=0xA1; consecutive Valid beats give 0xB2 then 0xC3; TURNBACK cycle has ADOE=0.
- Wrap-around: write 2 beats at idx 15 (ADIn=0x0000043C) -> store[15] and store[0] written; read back in same order.
- Miss: ADIn=0x00000808 with Write=0 for 4 cycles -> ADOE, Ready, Stop remain 0; state returns to IDLE after Frame=0.
- Burst limit: read 10 beats from idx 0 -> 8 beats transfer; Ready=0 and Stop=1 from the 9th beat until Frame=0; ADOE=0 in the following cycle.
- Reset mid-read: assert Reset during RDATA beat 2 -> ADOE=0 immediately (asynchronously); after release Busy=0 and a fresh write transaction completes correctly.
